// File: rtl/mm_pkg.sv
// Shared constants, entry FSM state enum and small helpers for the code entry path.
package mm_pkg;

  localparam int DIGIT_W = 3;
  localparam int DIGITS  = 4;
  localparam int CODE_W  = DIGITS * DIGIT_W;
  localparam int IDX_W   = $clog2(DIGITS);

  typedef enum logic [2:0] {
    ST_E_IDLE,
    ST_E_SETUP,
    ST_E_PRESS,
    ST_E_GAP,
    ST_E_DONE
  } entry_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Digit 0 is the most significant slice and is sent first.
  function automatic logic [DIGIT_W-1:0] get_digit(input logic [CODE_W-1:0] code,
                                                   input logic [IDX_W-1:0]  idx);
    return code[(DIGITS - 1 - int'(idx)) * DIGIT_W +: DIGIT_W];
  endfunction

endpackage

// File: rtl/code_entry_driver_if.sv
// Request/response bundle between a code source (master) and code_entry_driver (slave).
interface code_entry_driver_if;
  import mm_pkg::*;

  logic                start;
  logic                abort;
  logic                player_b;
  logic [CODE_W-1:0]   code_in;
  logic [DIGIT_W-1:0]  SW_out;
  logic                enterA_out;
  logic                enterB_out;
  logic                busy;
  logic                done;
  logic [IDX_W-1:0]    digit_idx;

  modport master (
    output start, abort, player_b, code_in,
    input  SW_out, enterA_out, enterB_out, busy, done, digit_idx
  );

  modport slave (
    input  start, abort, player_b, code_in,
    output SW_out, enterA_out, enterB_out, busy, done, digit_idx
  );

endinterface

// File: rtl/phase_timer.sv
// Loadable down-counter timing one SETUP/PRESS/GAP phase; expire marks the last cycle.
module phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic [W-1:0] value,
  output logic         expire
);

  // Stops at zero rather than wrapping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (value != '0) begin
      value <= value - 1'b1;
    end
  end

  assign expire = (value == W'(1));

endmodule

// File: rtl/code_entry_driver.sv
// Replays a latched 4-digit code as timed SW values and enter presses for player A or B.
module code_entry_driver
  import mm_pkg::*;
#(
  parameter int SETUP_CYCLES = 1,
  parameter int PRESS_CYCLES = 2,
  parameter int GAP_CYCLES   = 3
) (
  input  logic                clk,
  input  logic                reset,
  code_entry_driver_if.slave  bus
);

  localparam int TIMER_W = $clog2(max3(SETUP_CYCLES, PRESS_CYCLES, GAP_CYCLES) + 1);

  localparam logic [2:0] S_IDLE  = ST_E_IDLE;
  localparam logic [2:0] S_SETUP = ST_E_SETUP;
  localparam logic [2:0] S_PRESS = ST_E_PRESS;
  localparam logic [2:0] S_GAP   = ST_E_GAP;
  localparam logic [2:0] S_DONE  = ST_E_DONE;

  logic [2:0]          state;
  logic [2:0]          next_state;
  logic [CODE_W-1:0]   code_q;
  logic                player_q;
  logic [DIGIT_W-1:0]  sw_q;
  logic                enter_a_q;
  logic                enter_b_q;
  logic                busy_q;
  logic                done_q;
  logic [IDX_W-1:0]    idx_q;

  logic                timer_load;
  logic [TIMER_W-1:0]  timer_load_value;
  logic [TIMER_W-1:0]  timer_value;
  logic                timer_expire;
  logic                phase_end;

  phase_timer #(.W(TIMER_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_load_value),
    .value      (timer_value),
    .expire     (timer_expire)
  );

  // An empty counter also ends the phase so the FSM can never stall in a phase state.
  assign phase_end = timer_expire || (timer_value == '0);

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (bus.start && !bus.abort) next_state = S_SETUP;
      S_SETUP: if (phase_end) next_state = S_PRESS;
      S_PRESS: if (phase_end) next_state = S_GAP;
      S_GAP:   if (phase_end) next_state = (idx_q == IDX_W'(DIGITS - 1)) ? S_DONE : S_SETUP;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
    if (bus.abort && (state != S_IDLE)) next_state = S_IDLE;
  end

  always_comb begin
    timer_load       = (next_state != state) &&
                       ((next_state == S_SETUP) || (next_state == S_PRESS) || (next_state == S_GAP));
    timer_load_value = '0;
    case (next_state)
      S_SETUP: timer_load_value = TIMER_W'(SETUP_CYCLES);
      S_PRESS: timer_load_value = TIMER_W'(PRESS_CYCLES);
      S_GAP:   timer_load_value = TIMER_W'(GAP_CYCLES);
      default: timer_load_value = '0;
    endcase
  end

  // Outputs are registered from next_state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      code_q    <= '0;
      player_q  <= 1'b0;
      sw_q      <= '0;
      enter_a_q <= 1'b0;
      enter_b_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      idx_q     <= '0;
    end else begin
      state     <= next_state;
      done_q    <= (next_state == S_DONE);
      busy_q    <= (next_state == S_SETUP) || (next_state == S_PRESS) || (next_state == S_GAP);
      enter_a_q <= (next_state == S_PRESS) && !player_q;
      enter_b_q <= (next_state == S_PRESS) && player_q;
      if ((state == S_IDLE) && (next_state == S_SETUP)) begin
        code_q   <= bus.code_in;
        player_q <= bus.player_b;
        idx_q    <= '0;
        sw_q     <= get_digit(bus.code_in, '0);
      end else if ((state == S_GAP) && (next_state == S_SETUP)) begin
        idx_q    <= idx_q + 1'b1;
        sw_q     <= get_digit(code_q, IDX_W'(idx_q + 1'b1));
      end
    end
  end

  assign bus.SW_out     = sw_q;
  assign bus.enterA_out = enter_a_q;
  assign bus.enterB_out = enter_b_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.digit_idx  = idx_q;

endmodule
